// File: rtl/tuss_burst_gen_if.sv
// Handshake and drive bundle between the detection controller and the TUSS burst generator.
interface tuss_burst_gen_if #(
  parameter int NUM_W = 5
) ();
  logic             burst_en;
  logic             burst_rstn;
  logic [NUM_W-1:0] pulse_num;
  logic             io1;
  logic             io2;
  logic             burst_finish;
  logic             busy;
  logic [NUM_W-1:0] pulse_cnt;

  modport master (
    output burst_en, burst_rstn, pulse_num,
    input  io1, io2, burst_finish, busy, pulse_cnt
  );

  modport slave (
    input  burst_en, burst_rstn, pulse_num,
    output io1, io2, burst_finish, busy, pulse_cnt
  );
endinterface

// File: rtl/tuss_burst_gen.sv
// TUSS burst generator: complementary square wave on io1/io2 for pulse_num periods,
// then a one-cycle burst_finish and a wait for the controller's burst_rstn clear.
module tuss_burst_gen #(
  parameter int HALF_PERIOD = 625,
  parameter int CNT_W       = 10,
  parameter int NUM_W       = 5
) (
  input  logic            gclk,
  input  logic            rstn,
  tuss_burst_gen_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE_H,
    DRIVE_L,
    FINISH,
    WAIT_REL
  } state_t;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [1:0]       DRV_OFF   = 2'b00;
  localparam logic [1:0]       DRV_A     = 2'b01;
  localparam logic [1:0]       DRV_B     = 2'b10;

  state_t           state_p0, state_nxt;
  logic [CNT_W-1:0] half_cnt_p0, half_cnt_nxt;
  logic [NUM_W-1:0] pulse_cnt_p0, pulse_cnt_nxt;
  logic [NUM_W-1:0] num_p0;
  logic             num_load;
  logic             rel_seen_p0, rel_seen_nxt;
  logic [1:0]       drive_nxt, drive_p1;
  logic             finish_p1;
  logic             busy_p1;

  function automatic logic [NUM_W-1:0] sat_inc(input logic [NUM_W-1:0] cnt,
                                               input logic [NUM_W-1:0] lim);
    if (cnt >= lim) return cnt;
    return cnt + NUM_W'(1);
  endfunction

  function automatic logic half_done(input logic [CNT_W-1:0] cnt);
    return (cnt == HALF_LAST);
  endfunction

  always_comb begin
    state_nxt     = state_p0;
    half_cnt_nxt  = half_cnt_p0;
    pulse_cnt_nxt = pulse_cnt_p0;
    rel_seen_nxt  = rel_seen_p0;
    num_load      = 1'b0;

    case (state_p0)
      IDLE: begin
        rel_seen_nxt = 1'b0;
        if (bus.burst_en) begin
          num_load      = 1'b1;
          pulse_cnt_nxt = '0;
          half_cnt_nxt  = '0;
          state_nxt     = (bus.pulse_num == '0) ? FINISH : DRIVE_H;
        end
      end
      DRIVE_H: begin
        if (half_done(half_cnt_p0)) begin
          half_cnt_nxt = '0;
          state_nxt    = DRIVE_L;
        end else begin
          half_cnt_nxt = half_cnt_p0 + CNT_W'(1);
        end
      end
      DRIVE_L: begin
        if (half_done(half_cnt_p0)) begin
          half_cnt_nxt  = '0;
          pulse_cnt_nxt = sat_inc(pulse_cnt_p0, num_p0);
          state_nxt     = ((pulse_cnt_p0 + NUM_W'(1)) == num_p0) ? FINISH : DRIVE_H;
        end else begin
          half_cnt_nxt = half_cnt_p0 + CNT_W'(1);
        end
      end
      FINISH: begin
        state_nxt = WAIT_REL;
      end
      WAIT_REL: begin
        if (!bus.burst_en && rel_seen_p0) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if ((state_p0 == FINISH || state_p0 == WAIT_REL) && !bus.burst_rstn) rel_seen_nxt = 1'b1;

    // Soft clear wins over every transition; pulse_cnt is kept for readback.
    if (!bus.burst_rstn) begin
      state_nxt    = IDLE;
      half_cnt_nxt = '0;
    end
  end

  // Stage p0: control state, half-period and period counters.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      state_p0     <= IDLE;
      half_cnt_p0  <= '0;
      pulse_cnt_p0 <= '0;
      rel_seen_p0  <= 1'b0;
    end else begin
      state_p0     <= state_nxt;
      half_cnt_p0  <= half_cnt_nxt;
      pulse_cnt_p0 <= pulse_cnt_nxt;
      rel_seen_p0  <= rel_seen_nxt;
    end
  end

  always_ff @(posedge gclk) begin
    if (num_load) num_p0 <= bus.pulse_num;
  end

  always_comb begin
    drive_nxt = DRV_OFF;
    case (state_p0)
      DRIVE_H: drive_nxt = DRV_A;
      DRIVE_L: drive_nxt = DRV_B;
      default: drive_nxt = DRV_OFF;
    endcase
  end

  // Stage p1: registered pin drive; one 2-bit register only ever holds 00, 01 or 10.
  always_ff @(posedge gclk or negedge rstn) begin
    if (!rstn) begin
      drive_p1  <= DRV_OFF;
      finish_p1 <= 1'b0;
      busy_p1   <= 1'b0;
    end else if (!bus.burst_rstn) begin
      drive_p1  <= DRV_OFF;
      finish_p1 <= 1'b0;
      busy_p1   <= 1'b0;
    end else begin
      drive_p1  <= drive_nxt;
      finish_p1 <= (state_p0 == FINISH);
      busy_p1   <= (state_p0 != IDLE);
    end
  end

  assign bus.io1          = drive_p1[0];
  assign bus.io2          = drive_p1[1];
  assign bus.burst_finish = finish_p1;
  assign bus.busy         = busy_p1;
  assign bus.pulse_cnt    = pulse_cnt_p0;

endmodule
